// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared states, access sizes, funct3 codes and alignment helper for the load/store unit
package lsu_pkg;

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} lsu_state_e;

    // Encoding matches funct3[1:0], so a size is a direct cast of those bits.
    typedef enum logic [1:0] {BYTE, HALF, WORD, DOUBLE} lsu_size_e;

    localparam logic [2:0] F3_B   = 3'b000;
    localparam logic [2:0] F3_H   = 3'b001;
    localparam logic [2:0] F3_W   = 3'b010;
    localparam logic [2:0] F3_D   = 3'b011;
    localparam logic [2:0] F3_BU  = 3'b100;
    localparam logic [2:0] F3_HU  = 3'b101;
    localparam logic [2:0] F3_WU  = 3'b110;
    localparam logic [2:0] F3_BAD = 3'b111;

    function automatic logic misaligned(lsu_size_e size, logic [2:0] offset);
        case (size)
            BYTE:    return 1'b0;
            HALF:    return offset[0];
            WORD:    return |offset[1:0];
            default: return |offset;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - request/response and data-memory signals of the load/store unit
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic        resp_err;
    logic [63:0] mem_address;
    logic [63:0] mem_write_data;
    logic        mem_write_en;
    logic        mem_read_en;
    logic [63:0] mem_read_data;

    modport master (
        input  req_valid, req_write, req_funct3, req_addr, req_wdata, mem_read_data,
        output req_ready, resp_valid, resp_rdata, resp_err,
               mem_address, mem_write_data, mem_write_en, mem_read_en
    );

    modport slave (
        output req_valid, req_write, req_funct3, req_addr, req_wdata, mem_read_data,
        input  req_ready, resp_valid, resp_rdata, resp_err,
               mem_address, mem_write_data, mem_write_en, mem_read_en
    );
endinterface

// File: rtl/lsu_lane_align.sv
// rtl/lsu_lane_align.sv - combinational lane extraction/extension for loads and lane merge for stores
module lsu_lane_align
    import lsu_pkg::*;
(
    input  lsu_size_e   size_i,
    input  logic        signed_i,
    input  logic [2:0]  offset_i,
    input  logic [63:0] rdata_i,
    input  logic [63:0] old_i,
    input  logic [63:0] wdata_i,
    output logic [63:0] load_o,
    output logic [63:0] merge_o
);
    logic [2:0]  lane_off;
    logic [5:0]  shamt;
    logic [63:0] lane_mask;
    logic [63:0] shifted;

    always_comb begin
        lane_off  = offset_i;
        lane_mask = '1;
        // Offset bits below the access size are dropped, giving forced alignment.
        case (size_i)
            BYTE: lane_mask = 64'h0000_0000_0000_00FF;
            HALF: begin
                lane_mask = 64'h0000_0000_0000_FFFF;
                lane_off  = {offset_i[2:1], 1'b0};
            end
            WORD: begin
                lane_mask = 64'h0000_0000_FFFF_FFFF;
                lane_off  = {offset_i[2], 2'b00};
            end
            default: lane_off = 3'b000;
        endcase
        shamt   = {lane_off, 3'b000};
        shifted = rdata_i >> shamt;
        load_o  = shifted & lane_mask;
        if (signed_i) begin
            case (size_i)
                BYTE:    load_o = {{56{shifted[7]}}, shifted[7:0]};
                HALF:    load_o = {{48{shifted[15]}}, shifted[15:0]};
                WORD:    load_o = {{32{shifted[31]}}, shifted[31:0]};
                default: load_o = shifted;
            endcase
        end
        merge_o = (old_i & ~(lane_mask << shamt)) | ((wdata_i & lane_mask) << shamt);
    end
endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - data-memory initiator with RMW sub-word stores; LSU_MISALIGN_TRAP_EN enables error traps
module load_store_unit
    import lsu_pkg::*;
(
    input  logic           clk,
    input  logic           rstn,
    load_store_unit_if.master bus
);
    lsu_state_e  state_q, state_d;
    logic [63:0] addr_q, addr_d;
    logic [63:0] wdata_q, wdata_d;
    logic [2:0]  funct3_q, funct3_d;
    logic        write_q, write_d;
    logic [63:0] old_q, old_d;
    logic [63:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        req_err;
    logic [63:0] load_data;
    logic [63:0] merge_data;

    lsu_lane_align u_align (
        .size_i   (lsu_size_e'(funct3_q[1:0])),
        .signed_i (~funct3_q[2]),
        .offset_i (addr_q[2:0]),
        .rdata_i  (bus.mem_read_data),
        .old_i    (old_q),
        .wdata_i  (wdata_q),
        .load_o   (load_data),
        .merge_o  (merge_data)
    );

    always_comb begin
`ifdef LSU_MISALIGN_TRAP_EN
        req_err = misaligned(lsu_size_e'(bus.req_funct3[1:0]), bus.req_addr[2:0])
                  || (bus.req_write ? bus.req_funct3[2] : (bus.req_funct3 == F3_BAD));
`else
        req_err = 1'b0;
`endif
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        funct3_d = funct3_q;
        write_d  = write_q;
        old_d    = old_q;
        rdata_d  = rdata_q;
        err_d    = err_q;

        bus.req_ready      = (state_q == IDLE) && rstn;
        bus.resp_valid     = (state_q == RESP);
        bus.resp_rdata     = (state_q == RESP) ? rdata_q : 64'h0;
        bus.resp_err       = (state_q == RESP) && err_q;
        bus.mem_read_en    = (state_q == READ);
        bus.mem_write_en   = (state_q == WRITE);
        bus.mem_address    = (state_q == READ || state_q == WRITE) ? {addr_q[63:3], 3'b000} : 64'h0;
        bus.mem_write_data = (state_q == WRITE) ? merge_data : 64'h0;

        case (state_q)
            IDLE: if (bus.req_valid) begin
                addr_d   = bus.req_addr;
                wdata_d  = bus.req_wdata;
                funct3_d = bus.req_funct3;
                write_d  = bus.req_write;
                rdata_d  = 64'h0;
                err_d    = req_err;
                if (req_err)
                    state_d = RESP;
                else if (bus.req_write && bus.req_funct3[1:0] == F3_D[1:0])
                    state_d = WRITE;
                else
                    state_d = READ;
            end
            READ: begin
                if (write_q) begin
                    old_d   = bus.mem_read_data;
                    state_d = WRITE;
                end else begin
                    rdata_d = load_data;
                    state_d = RESP;
                end
            end
            WRITE:   state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            funct3_q <= '0;
            write_q  <= 1'b0;
            old_q    <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            funct3_q <= funct3_d;
            write_q  <= write_d;
            old_q    <= old_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed and randomized checks of load_store_unit against a byte-level memory model
module tb_load_store_unit;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    load_store_unit_if bus();
    load_store_unit dut (.clk(clk), .rstn(rstn), .bus(bus));

    localparam logic [63:0] PRE = 64'h8877665544332211;

    logic [63:0] mem [16];
    logic [63:0] ref_mem [16];
    logic        init_mem = 1'b1;

    assign bus.mem_read_data = mem[bus.mem_address[6:3]];

    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 16; i++) mem[i] <= (i == 2) ? PRE : 64'h0;
        end else if (bus.mem_write_en) begin
            mem[bus.mem_address[6:3]] <= bus.mem_write_data;
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_load(input logic [63:0] word, input logic [2:0] f3, input logic [63:0] a);
        int nb = 1 << f3[1:0];
        int off = (int'(a[2:0]) / nb) * nb;
        logic [63:0] v = 64'h0;
        for (int k = 0; k < nb; k++) v[8*k +: 8] = word[8*(off+k) +: 8];
        if (!f3[2] && v[8*nb-1])
            for (int k = nb; k < 8; k++) v[8*k +: 8] = 8'hFF;
        return v;
    endfunction

    function automatic logic [63:0] ref_store(input logic [63:0] old, input logic [2:0] f3,
                                              input logic [63:0] a, input logic [63:0] wd);
        int nb = 1 << f3[1:0];
        int off = (int'(a[2:0]) / nb) * nb;
        logic [63:0] r = old;
        for (int k = 0; k < nb; k++) r[8*(off+k) +: 8] = wd[8*k +: 8];
        return r;
    endfunction

    function automatic logic ref_err(input logic w, input logic [2:0] f3, input logic [63:0] a);
`ifdef LSU_MISALIGN_TRAP_EN
        int nb = 1 << f3[1:0];
        return ((int'(a[2:0]) % nb) != 0) || (w ? f3[2] : (f3 == 3'b111));
`else
        return 1'b0 & w & f3[0] & a[0];
`endif
    endfunction

    task automatic run_op(input string tag, input logic w, input logic [2:0] f3,
                          input logic [63:0] a, input logic [63:0] wd, output logic [63:0] rdata_o);
        int idx = int'(a[6:3]);
        logic        e_err = ref_err(w, f3, a);
        logic [63:0] e_rdata = (w || e_err) ? 64'h0 : ref_load(ref_mem[idx], f3, a);
        logic [7:0]  e_rd, e_wr, e_rv, g_rd, g_wr, g_rv;
        logic [63:0] g_rdata = 64'h0, g_wdata = 64'h0, g_addr = 64'h0;
        logic        g_err = 1'b0;
        int          leak = 0;
        if (!e_err && w) ref_mem[idx] = ref_store(ref_mem[idx], f3, a, wd);
        if (e_err)                    begin e_rd = 8'h00; e_wr = 8'h00; e_rv = 8'h02; end
        else if (!w)                  begin e_rd = 8'h02; e_wr = 8'h00; e_rv = 8'h04; end
        else if (f3[1:0] == 2'b11)    begin e_rd = 8'h00; e_wr = 8'h02; e_rv = 8'h04; end
        else                          begin e_rd = 8'h02; e_wr = 8'h04; e_rv = 8'h08; end
        g_rd = 0; g_wr = 0; g_rv = 0;

        check({tag, ".ready"}, {63'h0, bus.req_ready}, 64'h1);
        bus.req_valid = 1'b1; bus.req_write = w; bus.req_funct3 = f3;
        bus.req_addr = a; bus.req_wdata = wd;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.req_write = ~w;
        bus.req_funct3 = 3'($urandom);
        bus.req_addr = {$urandom, $urandom};
        bus.req_wdata = {$urandom, $urandom};
        for (int c = 1; c < 7; c++) begin
            @(negedge clk);
            if (bus.mem_read_en) g_rd[c] = 1'b1;
            if (bus.mem_write_en) begin g_wr[c] = 1'b1; g_wdata = bus.mem_write_data; end
            if (bus.mem_read_en || bus.mem_write_en) g_addr = bus.mem_address;
            else if (bus.mem_address != 0) leak++;
            if (!bus.mem_write_en && bus.mem_write_data != 0) leak++;
            if (bus.resp_valid) begin g_rv[c] = 1'b1; g_rdata = bus.resp_rdata; g_err = bus.resp_err; end
            else if (bus.resp_rdata != 0 || bus.resp_err) leak++;
        end
        check({tag, ".rd_cycles"}, {56'h0, g_rd}, {56'h0, e_rd});
        check({tag, ".wr_cycles"}, {56'h0, g_wr}, {56'h0, e_wr});
        check({tag, ".resp_cycles"}, {56'h0, g_rv}, {56'h0, e_rv});
        check({tag, ".rdata"}, g_rdata, e_rdata);
        check({tag, ".err"}, {63'h0, g_err}, {63'h0, e_err});
        check({tag, ".idle_outputs"}, 64'(leak), 64'h0);
        if (e_rd != 0 || e_wr != 0) check({tag, ".addr"}, g_addr, {a[63:3], 3'b000});
        if (e_wr != 0) check({tag, ".wdata"}, g_wdata, ref_mem[idx]);
        check({tag, ".mem"}, mem[idx], ref_mem[idx]);
        rdata_o = g_rdata;
    endtask

    initial begin
        logic [63:0] r;
        int hs [2];
        int nhs, nresp;
        for (int i = 0; i < 16; i++) ref_mem[i] = (i == 2) ? PRE : 64'h0;
        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_funct3 = 3'b0;
        bus.req_addr = 64'h0; bus.req_wdata = 64'h0;
        repeat (3) @(negedge clk);
        init_mem = 1'b0;
        rstn = 1'b1;
        #1;
        check("reset.ready", {63'h0, bus.req_ready}, 64'h1);
        check("reset.resp_valid", {63'h0, bus.resp_valid}, 64'h0);
        check("reset.mem_en", {62'h0, bus.mem_read_en, bus.mem_write_en}, 64'h0);
        @(negedge clk);

        run_op("lb17", 1'b0, 3'b000, 64'h17, 64'h0, r);
        check("lb17.value", r, ref_err(1'b0, 3'b000, 64'h17) ? 64'h0 : 64'hFFFFFFFFFFFFFF88);
        run_op("lbu17", 1'b0, 3'b100, 64'h17, 64'h0, r);
        check("lbu17.value", r, 64'h0000000000000088);
        run_op("sh12", 1'b1, 3'b001, 64'h12, 64'hABCD, r);
        check("sh12.word", mem[2], 64'h88776655ABCD2211);
        run_op("ld10", 1'b0, 3'b011, 64'h10, 64'h0, r);
        check("ld10.value", r, 64'h88776655ABCD2211);
        run_op("sd18", 1'b1, 3'b011, 64'h18, 64'h0123456789ABCDEF, r);
        check("sd18.word", mem[3], 64'h0123456789ABCDEF);
        run_op("lw11", 1'b0, 3'b010, 64'h11, 64'h0, r);
`ifdef LSU_MISALIGN_TRAP_EN
        check("lw11.value", r, 64'h0);
`else
        check("lw11.value", r, 64'h0000000055ABCD11 & 64'h0 | ref_load(ref_mem[2], 3'b010, 64'h10));
`endif

        // Back-to-back LDs with req_valid held high.
        nhs = 0; nresp = 0;
        bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_funct3 = 3'b011; bus.req_addr = 64'h10;
        for (int c = 0; c < 10; c++) begin
            if (bus.req_ready && bus.req_valid && nhs < 2) begin hs[nhs] = c; nhs++; end
            if (bus.resp_valid) begin
                nresp++;
                check("b2b.rdata", bus.resp_rdata, ref_mem[2]);
            end
            @(posedge clk);
            #1;
            if (nhs == 2) bus.req_valid = 1'b0;
            @(negedge clk);
        end
        check("b2b.handshakes", 64'(nhs), 64'd2);
        check("b2b.spacing", 64'(hs[1] - hs[0]), 64'd3);
        check("b2b.resp_count", 64'(nresp), 64'd2);

        // Reset during the WRITE of an SB must leave the word untouched.
        bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_funct3 = 3'b000;
        bus.req_addr = 64'h10; bus.req_wdata = 64'h5A;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        check("rst.read_phase", {63'h0, bus.mem_read_en}, 64'h1);
        @(negedge clk);
        check("rst.write_phase", {63'h0, bus.mem_write_en}, 64'h1);
        #1;
        rstn = 1'b0;
        #1;
        check("rst.write_drop", {63'h0, bus.mem_write_en}, 64'h0);
        check("rst.addr_zero", bus.mem_address, 64'h0);
        @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        #1;
        check("rst.ready", {63'h0, bus.req_ready}, 64'h1);
        check("rst.resp_valid", {63'h0, bus.resp_valid}, 64'h0);
        @(negedge clk);
        check("rst.word", mem[2], ref_mem[2]);

        for (int n = 0; n < 60; n++) begin
            logic w = 1'($urandom);
            logic [2:0] f3 = 3'($urandom);
            logic [63:0] a = 64'($urandom_range(0, 127));
            logic [63:0] wd = {$urandom, $urandom};
            run_op($sformatf("rand%0d", n), w, f3, a, wd, r);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
